tm1638_frame_scheduler: RTL and testbench

Sits between the user frame source, the tm1638_driver and the single SPI TX FIFO. It decides when the driver sends a frame, either on a user update or on a periodic refresh, and counts the driver's 33 writes to detect frame completion. It also shares the FIFO write port with an auxiliary requester (key-scan/read commands) using frame-granular round-robin.

---
 rtl/tm1638_frame_scheduler.sv | 176 +++++++++++++++++
 tb/tb_tm1638_frame_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_frame_scheduler.sv
// tm1638_frame_scheduler: schedules driver frames (update/refresh) and shares the SPI FIFO with an aux requester
//   i_Clk, i_Rst_n                 : clock (state on falling edge), synchronous active-low reset
//   i_Segments/i_Leds/i_Update     : user frame and capture strobe
//   o_Segments/o_Leds/o_Valid      : frame and start strobe to tm1638_driver
//   i_Drv_Data/i_Drv_Write         : driver FIFO write port
//   o_Drv_FIFO_Full                : back-pressure to driver (forced high outside a frame)
//   i_Aux_Data/i_Aux_Req/o_Aux_Ack : auxiliary word requester
//   i_SPI_FIFO_Full/o_SPI_Data/o_SPI_Write : shared SPI TX FIFO write port
//   o_Busy/o_Frame_Done/o_Error    : status
module tm1638_frame_scheduler #(
    parameter int REFRESH_CYCLES  = 1000000,
    parameter int WORDS_PER_FRAME = 33,
    parameter int AUX_BURST       = 4,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic [63:0] i_Segments,
    input  logic [7:0]  i_Leds,
    input  logic        i_Update,
    output logic [63:0] o_Segments,
    output logic [7:0]  o_Leds,
    output logic        o_Valid,
    input  logic [16:0] i_Drv_Data,
    input  logic        i_Drv_Write,
    output logic        o_Drv_FIFO_Full,
    input  logic [16:0] i_Aux_Data,
    input  logic        i_Aux_Req,
    output logic        o_Aux_Ack,
    input  logic        i_SPI_FIFO_Full,
    output logic [16:0] o_SPI_Data,
    output logic        o_SPI_Write,
    output logic        o_Busy,
    output logic        o_Frame_Done,
    output logic        o_Error
);
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int WW = $clog2(WORDS_PER_FRAME + 1);
    localparam int BW = $clog2(AUX_BURST + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
    localparam logic [WW-1:0] WORD_LAST    = WW'(WORDS_PER_FRAME - 1);
    localparam logic [BW-1:0] BURST_LAST   = BW'(AUX_BURST - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, FRAME, AUX} state_t;

    state_t        state, state_next;
    logic [63:0]   stage_seg;
    logic [7:0]    stage_led;
    logic          pending;
    logic [RW-1:0] refresh_cnt;
    logic          last_grant_frame;
    logic [WW-1:0] word_cnt;
    logic [BW-1:0] burst_cnt;
    logic [TW-1:0] timeout_cnt;
    logic          frame_done;
    logic          go_frame, frame_last, timed_out;

    wire refresh_wrap = (REFRESH_CYCLES != 0) && (refresh_cnt == REFRESH_LAST);
    wire in_frame     = (state == START) || (state == FRAME);

    assign o_Busy       = state != IDLE;
    assign o_Frame_Done = frame_done && i_Rst_n;

    always_comb begin
        state_next      = state;
        o_Valid         = 1'b0;
        o_Aux_Ack       = 1'b0;
        o_SPI_Write     = 1'b0;
        o_SPI_Data      = '0;
        o_Drv_FIFO_Full = 1'b1;
        go_frame        = 1'b0;
        frame_last      = 1'b0;
        timed_out       = 1'b0;
        case (state)
            IDLE: begin
                // a pending frame yields to aux only when the frame had the last grant
                if (pending && (!last_grant_frame || !i_Aux_Req)) begin
                    state_next = START;
                    go_frame   = 1'b1;
                end else if (i_Aux_Req) begin
                    state_next = AUX;
                end
            end
            START: begin
                o_Valid         = 1'b1;
                o_SPI_Write     = i_Drv_Write;
                o_SPI_Data      = i_Drv_Write ? i_Drv_Data : '0;
                o_Drv_FIFO_Full = i_SPI_FIFO_Full;
                state_next      = FRAME;
            end
            FRAME: begin
                o_SPI_Write     = i_Drv_Write;
                o_SPI_Data      = i_Drv_Data;
                o_Drv_FIFO_Full = i_SPI_FIFO_Full;
                frame_last      = i_Drv_Write && (word_cnt == WORD_LAST);
                // a full FIFO is a legitimate stall, only an idle driver counts toward timeout
                timed_out       = !i_SPI_FIFO_Full && !i_Drv_Write && (timeout_cnt == TIMEOUT_LAST);
                if (frame_last || timed_out)
                    state_next = IDLE;
            end
            AUX: begin
                o_Aux_Ack   = i_Aux_Req && !i_SPI_FIFO_Full;
                o_SPI_Write = o_Aux_Ack;
                o_SPI_Data  = i_Aux_Data;
                if (!i_Aux_Req || (o_Aux_Ack && burst_cnt == BURST_LAST))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (!i_Rst_n) begin
            state_next      = IDLE;
            o_Valid         = 1'b0;
            o_Aux_Ack       = 1'b0;
            o_SPI_Write     = 1'b0;
            o_SPI_Data      = '0;
            o_Drv_FIFO_Full = 1'b1;
        end
    end

    always_ff @(negedge i_Clk)
        state <= i_Rst_n ? state_next : IDLE;

    always_ff @(negedge i_Clk) begin
        if (!i_Rst_n) begin
            stage_seg        <= '0;
            stage_led        <= '0;
            o_Segments       <= '0;
            o_Leds           <= '0;
            pending          <= 1'b0;
            refresh_cnt      <= '0;
            last_grant_frame <= 1'b0;
            word_cnt         <= '0;
            burst_cnt        <= '0;
            timeout_cnt      <= '0;
            frame_done       <= 1'b0;
            o_Error          <= 1'b0;
        end else begin
            if (i_Update) begin
                stage_seg <= i_Segments;
                stage_led <= i_Leds;
            end
            if (REFRESH_CYCLES != 0)
                refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + 1'b1;
            pending    <= i_Update || refresh_wrap || (pending && !go_frame);
            frame_done <= frame_last;
            if (go_frame) begin
                o_Segments <= stage_seg;
                o_Leds     <= stage_led;
            end
            if (state == IDLE)
                burst_cnt <= '0;
            else if (o_Aux_Ack)
                burst_cnt <= burst_cnt + 1'b1;
            if (state == START) begin
                word_cnt         <= '0;
                timeout_cnt      <= '0;
                last_grant_frame <= 1'b1;
            end
            if (state == FRAME) begin
                if (i_Drv_Write) begin
                    word_cnt    <= word_cnt + 1'b1;
                    timeout_cnt <= '0;
                end else if (!i_SPI_FIFO_Full) begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                end
            end
            if (state == AUX && state_next == IDLE)
                last_grant_frame <= 1'b0;
            // driver writes outside a frame are dropped and flagged
            if (timed_out || (i_Drv_Write && !in_frame))
                o_Error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tm1638_frame_scheduler.sv
// tb_tm1638_frame_scheduler: directed bench with a driver model and event scoreboard
module tb_tm1638_frame_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0, update = 1'b0, aux_req = 1'b0, spi_full = 1'b0, drv_write = 1'b0;
    logic [63:0] seg_in = '0;
    logic [7:0]  led_in = '0;
    logic [16:0] drv_data = '0, aux_data = 17'h1A5A5;
    logic [63:0] o_Segments;
    logic [7:0]  o_Leds;
    logic        o_Valid, o_Drv_FIFO_Full, o_Aux_Ack, o_SPI_Write, o_Busy, o_Frame_Done, o_Error;
    logic [16:0] o_SPI_Data;
    logic        zero = 1'b0;
    logic [63:0] nr_seg;
    logic [7:0]  nr_led;
    logic        nr_valid_o, nr_full, nr_ack, nr_wr, nr_busy, nr_done, nr_err;
    logic [16:0] nr_data;

    always #5 clk = ~clk;

    tm1638_frame_scheduler #(.REFRESH_CYCLES(200), .WORDS_PER_FRAME(33), .AUX_BURST(4), .TIMEOUT_CYCLES(16)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Segments(seg_in), .i_Leds(led_in), .i_Update(update),
        .o_Segments(o_Segments), .o_Leds(o_Leds), .o_Valid(o_Valid),
        .i_Drv_Data(drv_data), .i_Drv_Write(drv_write), .o_Drv_FIFO_Full(o_Drv_FIFO_Full),
        .i_Aux_Data(aux_data), .i_Aux_Req(aux_req), .o_Aux_Ack(o_Aux_Ack),
        .i_SPI_FIFO_Full(spi_full), .o_SPI_Data(o_SPI_Data), .o_SPI_Write(o_SPI_Write),
        .o_Busy(o_Busy), .o_Frame_Done(o_Frame_Done), .o_Error(o_Error));

    tm1638_frame_scheduler #(.REFRESH_CYCLES(0), .WORDS_PER_FRAME(33), .AUX_BURST(4), .TIMEOUT_CYCLES(16)) dut_nr (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Segments(64'd0), .i_Leds(8'd0), .i_Update(zero),
        .o_Segments(nr_seg), .o_Leds(nr_led), .o_Valid(nr_valid_o),
        .i_Drv_Data(17'd0), .i_Drv_Write(zero), .o_Drv_FIFO_Full(nr_full),
        .i_Aux_Data(17'd0), .i_Aux_Req(zero), .o_Aux_Ack(nr_ack),
        .i_SPI_FIFO_Full(zero), .o_SPI_Data(nr_data), .o_SPI_Write(nr_wr),
        .o_Busy(nr_busy), .o_Frame_Done(nr_done), .o_Error(nr_err));

    bit          drv_active, drv_stall, force_wr, in_frame, last_wr;
    logic [16:0] last_data;
    logic [7:0]  last_led;
    int          drv_idx, cyc, n_valid, n_done, n_spi_wr, frame_words, done_words, aux_run, viol;
    int          nr_valid, data_err, err_cyc = -1, n_tests, n_fail;
    logic [63:0] valid_seg[$];
    int          valid_cyc[$];
    int          glog[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic sample();
        cyc++;
        last_wr   = o_SPI_Write;
        last_data = o_SPI_Data;
        if (drv_write && drv_active) begin
            drv_idx++;
            if (drv_idx == 33) drv_active = 0;
        end
        if (o_Aux_Ack) begin
            aux_run++;
            if (in_frame) viol++;
            if (o_SPI_Data !== aux_data) data_err++;
        end else if (aux_run > 0) begin
            glog.push_back(aux_run);
            aux_run = 0;
        end
        if (o_SPI_Write && !o_Aux_Ack) begin
            frame_words++;
            if (o_SPI_Data !== drv_data) data_err++;
        end
        if (o_SPI_Write) n_spi_wr++;
        if (o_Valid) begin
            n_valid++;
            valid_seg.push_back(o_Segments);
            valid_cyc.push_back(cyc);
            glog.push_back(-1);
            last_led    = o_Leds;
            frame_words = 0;
            in_frame    = 1;
            drv_active  = 1;
            drv_idx     = 0;
        end
        if (o_Frame_Done) begin
            n_done++;
            done_words = frame_words;
            in_frame   = 0;
        end
        if (o_Error && err_cyc < 0) err_cyc = cyc;
        if (nr_valid_o) nr_valid++;
        if (!rst_n) begin
            in_frame   = 0;
            drv_active = 0;
        end
    endtask

    task automatic step();
        drv_write = force_wr || (drv_active && !drv_stall && !spi_full);
        drv_data  = 17'h10000 | 17'(drv_idx);
        #1;
        sample();
        @(posedge clk);
    endtask

    task automatic run_until_done(input int budget);
        int d0 = n_done;
        done_words = -1;
        for (int i = 0; i < budget && n_done == d0; i++) step();
    endtask

    task automatic run_until_valid(input int budget);
        int v0 = n_valid;
        for (int i = 0; i < budget && n_valid == v0; i++) step();
    endtask

    task automatic settle();
        int q = 0;
        for (int i = 0; i < 400 && q < 3; i++) begin
            step();
            q = o_Busy ? 0 : q + 1;
        end
    endtask

    function automatic int glog_at(input int idx);
        return (glog.size() > idx) ? glog[idx] : -99;
    endfunction

    function automatic logic [63:0] seg_at(input int idx);
        return (valid_seg.size() > idx) ? valid_seg[idx] : 64'hDEAD;
    endfunction

    initial begin
        int b, w0, d0, vc;
        @(posedge clk);
        repeat (3) step();
        check("rst_valid", o_Valid, 0);
        check("rst_drv_full", o_Drv_FIFO_Full, 1);
        check("rst_spi_wr", o_SPI_Write, 0);
        check("rst_spi_data", o_SPI_Data, 0);
        check("rst_ack", o_Aux_Ack, 0);
        check("rst_busy", o_Busy, 0);
        check("rst_err", o_Error, 0);
        check("rst_seg", o_Segments, 0);
        check("rst_done", o_Frame_Done, 0);
        rst_n = 1'b1;
        step();

        seg_in = 64'h0123456789ABCDEF;
        led_in = 8'hA5;
        update = 1'b1;
        step();
        update = 1'b0;
        run_until_done(100);
        check("t1_valids", n_valid, 1);
        check("t1_seg", seg_at(0), 64'h0123456789ABCDEF);
        check("t1_led", last_led, 8'hA5);
        check("t1_done", n_done, 1);
        check("t1_words", done_words, 33);
        check("t1_done_pulse", o_Frame_Done, 0);
        check("t1_busy", o_Busy, 0);

        b = valid_cyc.size();
        run_until_valid(300);
        run_until_done(100);
        check("t2_words1", done_words, 33);
        run_until_valid(300);
        run_until_done(100);
        check("t2_words2", done_words, 33);
        check("t2_frames", valid_cyc.size() - b, 2);
        check("t2_period", (valid_cyc.size() >= b + 2) ? valid_cyc[b+1] - valid_cyc[b] : -1, 200);
        check("t2_err", o_Error, 0);
        settle();

        b = glog.size();
        update  = 1'b1;
        aux_req = 1'b1;
        for (int i = 0; i < 300 && glog.size() < b + 4; i++) step();
        update  = 1'b0;
        aux_req = 1'b0;
        check("t3_grant0_aux", glog_at(b), 4);
        check("t3_grant1_frame", glog_at(b + 1), -1);
        check("t3_grant2_aux", glog_at(b + 2), 4);
        check("t3_grant3_frame", glog_at(b + 3), -1);
        settle();
        check("t3_ack_in_frame", viol, 0);
        check("t3_words", done_words, 33);

        seg_in = 64'hC0C0_C0C0_C0C0_C0C0;
        update = 1'b1;
        step();
        update = 1'b0;
        for (int i = 0; i < 100 && !(in_frame && frame_words >= 10); i++) step();
        spi_full = 1'b1;
        w0 = n_spi_wr;
        repeat (1000) step();
        check("t4_stall_writes", n_spi_wr - w0, 0);
        check("t4_stall_err", o_Error, 0);
        check("t4_stall_busy", o_Busy, 1);
        spi_full = 1'b0;
        run_until_done(100);
        check("t4_words", done_words, 33);
        settle();

        run_until_valid(300);
        run_until_done(100);
        b = valid_seg.size();
        seg_in = 64'hAAAA_0000_AAAA_0000;
        update = 1'b1;
        step();
        seg_in = 64'hBBBB_1111_BBBB_1111;
        step();
        update = 1'b0;
        run_until_done(100);
        run_until_done(100);
        check("t5_first_A", seg_at(b), 64'hAAAA_0000_AAAA_0000);
        check("t5_second_B", seg_at(b + 1), 64'hBBBB_1111_BBBB_1111);
        check("t5_words", done_words, 33);

        drv_stall = 1;
        d0 = n_done;
        b = valid_cyc.size();
        err_cyc = -1;
        update = 1'b1;
        step();
        update = 1'b0;
        for (int i = 0; i < 60 && err_cyc < 0; i++) step();
        vc = (valid_cyc.size() > b) ? valid_cyc[b] : 0;
        check("t6_err", o_Error, 1);
        check("t6_latency", err_cyc - vc, 17);
        check("t6_no_done", n_done - d0, 0);
        check("t6_idle", o_Busy, 0);
        repeat (5) step();
        check("t6_sticky", o_Error, 1);
        drv_stall  = 0;
        drv_active = 0;
        rst_n = 1'b0;
        step();
        step();
        check("t6_rst_err", o_Error, 0);
        check("t6_rst_busy", o_Busy, 0);
        check("t6_rst_full", o_Drv_FIFO_Full, 1);
        rst_n = 1'b1;
        step();

        force_wr = 1;
        step();
        force_wr = 0;
        check("t7_dropped_wr", last_wr, 0);
        check("t7_data_zero", last_data, 0);
        check("t7_err", o_Error, 1);

        check("nr_no_refresh", nr_valid, 0);
        check("data_passthrough", data_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
